// File: rtl/median_select.sv
// median_select: iterative quickselect controller. Each pass receives the
// partition counts/extremes for the current pivot, decides which side
// holds the median, and either finishes or requests another pass.
module median_select #(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BUFF_SIZE_BIT-1:0] win_size,
  input  logic [7:0]               init_pivot,
  input  logic                     fill_done,
  input  logic [BUFF_SIZE_BIT-1:0] lower_size,
  input  logic [BUFF_SIZE_BIT-1:0] equal_size,
  input  logic [BUFF_SIZE_BIT-1:0] larger_size,
  input  logic [7:0]               min_lower,
  input  logic [7:0]               max_lower,
  input  logic [7:0]               min_larger,
  input  logic [7:0]               max_larger,
  output logic [7:0]               pivot,
  output logic [BUFF_SIZE_BIT-1:0] buff_size,
  output logic                     send_req,
  output logic                     sending,
  output logic [7:0]               median,
  output logic                     median_valid,
  input  logic                     median_ready,
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FILL, S_DECIDE, S_REQ, S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               pivot_q, pivot_d;
  logic [BUFF_SIZE_BIT-1:0] buff_q, buff_d;
  logic [BUFF_SIZE_BIT-1:0] k_q, k_d;
  logic [7:0]               median_q, median_d;

  // partition results captured when the fill completes
  logic [BUFF_SIZE_BIT-1:0] lsz_q, esz_q, gsz_q;
  logic [7:0]               minl_q, maxl_q, ming_q, maxg_q;

  logic [BUFF_SIZE_BIT-1:0] le_sum;
  logic                     go_lower, hit;
  logic [7:0]               t_min, t_max, mid;
  logic [8:0]               mid_sum;

  // decision datapath: L+E cannot exceed buff_size, so no wider sum needed
  assign le_sum   = lsz_q + esz_q;
  assign go_lower = (k_q < lsz_q);
  assign hit      = !go_lower && (k_q < le_sum);
  assign t_min    = go_lower ? minl_q : ming_q;
  assign t_max    = go_lower ? maxl_q : maxg_q;
  // rounding up keeps min < new pivot <= max, so the range always shrinks
  assign mid_sum  = {1'b0, t_min} + {1'b0, t_max} + 9'd1;
  assign mid      = 8'(mid_sum >> 1);

  // next-state and datapath update
  always_comb begin
    state_d  = state_q;
    pivot_d  = pivot_q;
    buff_d   = buff_q;
    k_d      = k_q;
    median_d = median_q;
    case (state_q)
      S_IDLE: if (start) begin
        pivot_d = init_pivot;
        buff_d  = win_size;
        k_d     = (win_size - BUFF_SIZE_BIT'(1)) >> 1;
        state_d = S_WAIT_FILL;
      end
      S_WAIT_FILL: if (fill_done) state_d = S_DECIDE;
      S_DECIDE: begin
        if (hit) begin
          median_d = pivot_q;
          state_d  = S_OUT;
        end else begin
          if (go_lower) begin
            buff_d = lsz_q;
          end else begin
            buff_d = gsz_q;
            k_d    = k_q - le_sum;
          end
          if (t_min == t_max) begin
            median_d = t_min;
            state_d  = S_OUT;
          end else begin
            pivot_d = mid;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: state_d = S_WAIT_FILL;
      S_OUT: if (median_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pivot_q  <= '0;
      buff_q   <= '0;
      k_q      <= '0;
      median_q <= '0;
    end else begin
      state_q  <= state_d;
      pivot_q  <= pivot_d;
      buff_q   <= buff_d;
      k_q      <= k_d;
      median_q <= median_d;
    end
  end

  // capture partition results on the accepted fill_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsz_q  <= '0;
      esz_q  <= '0;
      gsz_q  <= '0;
      minl_q <= '0;
      maxl_q <= '0;
      ming_q <= '0;
      maxg_q <= '0;
    end else if (state_q == S_WAIT_FILL && fill_done) begin
      lsz_q  <= lower_size;
      esz_q  <= equal_size;
      gsz_q  <= larger_size;
      minl_q <= min_lower;
      maxl_q <= max_lower;
      ming_q <= min_larger;
      maxg_q <= max_larger;
    end
  end

  assign pivot        = pivot_q;
  assign buff_size    = buff_q;
  assign median       = median_q;
  assign send_req     = (state_q == S_REQ);
  assign sending      = (state_q == S_DECIDE) || (state_q == S_REQ);
  assign median_valid = (state_q == S_OUT);
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_median_select.sv
// Bench for median_select: acts as the partition stage over a real pixel
// buffer and checks the controller converges on the true median.
module tb_median_select;
  localparam int BS = 32;
  localparam int BW = $clog2(BS) + 1;

  logic          clk = 1'b0;
  logic          rst, start, fill_done, median_ready;
  logic [BW-1:0] win_size, lower_size, equal_size, larger_size;
  logic [7:0]    init_pivot, min_lower, max_lower, min_larger, max_larger;
  logic [7:0]    pivot, median;
  logic [BW-1:0] buff_size;
  logic          send_req, sending, median_valid, busy;

  median_select #(.BUFF_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .start(start), .win_size(win_size),
    .init_pivot(init_pivot), .fill_done(fill_done),
    .lower_size(lower_size), .equal_size(equal_size), .larger_size(larger_size),
    .min_lower(min_lower), .max_lower(max_lower),
    .min_larger(min_larger), .max_larger(max_larger),
    .pivot(pivot), .buff_size(buff_size), .send_req(send_req), .sending(sending),
    .median(median), .median_valid(median_valid), .median_ready(median_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] mdl_pivot = '0;
  logic [BW-1:0] mdl_buff = '0;
  bit         mdl_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // per-cycle compare of the registered pivot/size against the model
  always @(negedge clk) begin
    #2;
    if (mdl_on) begin
      chk("pivot", pivot, mdl_pivot);
      chk("buff_size", buff_size, mdl_buff);
      if (send_req) chk("send_req_implies_sending", sending, 1);
      if (median_valid) chk("valid_implies_busy", busy, 1);
    end
  end

  task automatic scramble();
    lower_size  = BW'($urandom);
    equal_size  = BW'($urandom);
    larger_size = BW'($urandom);
    min_lower   = 8'($urandom);
    max_lower   = 8'($urandom);
    min_larger  = 8'($urandom);
    max_larger  = 8'($urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pivot"}, pivot, 0);
    chk({tag, "_buff"}, buff_size, 0);
    chk({tag, "_median"}, median, 0);
    chk({tag, "_valid"}, median_valid, 0);
    chk({tag, "_sreq"}, send_req, 0);
    chk({tag, "_sending"}, sending, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // called at a negedge while idle; returns in WAIT_FILL
  task automatic begin_win(input int n, input int p);
    start = 1'b1; win_size = BW'(n); init_pivot = 8'(p);
    step();
    start = 1'b0; win_size = BW'($urandom); init_pivot = 8'($urandom);
    mdl_pivot = 8'(p); mdl_buff = BW'(n);
    chk("wait_busy", busy, 1);
    chk("wait_sending", sending, 0);
  endtask

  // present one fill result; returns in DECIDE
  task automatic fill(input int l, input int e, input int g,
                      input int mnl, input int mxl, input int mng, input int mxg);
    lower_size = BW'(l); equal_size = BW'(e); larger_size = BW'(g);
    min_lower = 8'(mnl); max_lower = 8'(mxl); min_larger = 8'(mng); max_larger = 8'(mxg);
    fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    scramble();
    chk("decide_sending", sending, 1);
    chk("decide_sreq", send_req, 0);
    chk("decide_valid", median_valid, 0);
  endtask

  task automatic expect_req(input int p, input int b);
    step();
    chk("req_pulse", send_req, 1);
    mdl_pivot = 8'(p); mdl_buff = BW'(b);
    step();
    chk("req_one_cycle", send_req, 0);
    chk("refill_sending", sending, 0);
    chk("refill_busy", busy, 1);
  endtask

  task automatic expect_out(input int m, input int b);
    step();
    chk("out_valid", median_valid, 1);
    chk("median", median, m);
    chk("out_sreq", send_req, 0);
    chk("out_sending", sending, 0);
    mdl_buff = BW'(b);
  endtask

  task automatic handshake(input int stall, input int m);
    repeat (stall) begin
      start = 1'b1;
      step();
      chk("stall_valid", median_valid, 1);
      chk("stall_median", median, m);
    end
    median_ready = 1'b1; start = 1'b1;
    step();
    median_ready = 1'b0; start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_valid", median_valid, 0);
    fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    chk("start_and_fill_ignored", busy, 0);
  endtask

  task automatic run_random();
    int n, base, spread, pv, m, mn, mx, np;
    int pix[$], srt[$], cur[$], lo[$], eq[$], hi[$], tgt[$];
    bit done;
    int sel;
    n = $urandom_range(1, BS);
    base = $urandom_range(0, 255);
    sel = $urandom_range(0, 3);
    spread = (sel == 0) ? 0 : (sel == 1) ? 3 : (sel == 2) ? 20 : 255;
    for (int i = 0; i < n; i++) begin
      int v;
      v = base + $urandom_range(0, spread);
      pix.push_back(v > 255 ? 255 : v);
    end
    srt = pix;
    srt.sort();
    m = srt[(n - 1) / 2];
    pv = $urandom_range(0, 255);
    cur = pix;
    done = 1'b0;
    begin_win(n, pv);
    for (int it = 0; it < 12 && !done; it++) begin
      int d;
      int xl0, xl1, xg0, xg1;
      d = $urandom_range(0, 2);
      repeat (d) begin
        step();
        chk("wait_sreq", send_req, 0);
        chk("wait_busy2", busy, 1);
      end
      lo.delete(); eq.delete(); hi.delete();
      foreach (cur[i]) begin
        if (cur[i] < pv) lo.push_back(cur[i]);
        else if (cur[i] == pv) eq.push_back(cur[i]);
        else hi.push_back(cur[i]);
      end
      xl0 = $urandom_range(0, 255); xl1 = $urandom_range(0, 255);
      xg0 = $urandom_range(0, 255); xg1 = $urandom_range(0, 255);
      if (lo.size() > 0) begin
        xl0 = 255; xl1 = 0;
        foreach (lo[i]) begin
          if (lo[i] < xl0) xl0 = lo[i];
          if (lo[i] > xl1) xl1 = lo[i];
        end
      end
      if (hi.size() > 0) begin
        xg0 = 255; xg1 = 0;
        foreach (hi[i]) begin
          if (hi[i] < xg0) xg0 = hi[i];
          if (hi[i] > xg1) xg1 = hi[i];
        end
      end
      fill(lo.size(), eq.size(), hi.size(), xl0, xl1, xg0, xg1);
      if (m == pv) begin
        expect_out(m, cur.size());
        done = 1'b1;
      end else begin
        tgt = (m < pv) ? lo : hi;
        mn = (m < pv) ? xl0 : xg0;
        mx = (m < pv) ? xl1 : xg1;
        if (mn == mx) begin
          expect_out(m, tgt.size());
          done = 1'b1;
        end else begin
          np = (mn + mx + 1) / 2;
          expect_req(np, tgt.size());
          cur = tgt;
          pv = np;
        end
      end
    end
    chk("converged", done, 1);
    if (done) begin
      handshake($urandom_range(0, 3), m);
    end else begin
      rst = 1'b1; mdl_pivot = '0; mdl_buff = '0;
      step();
      rst = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; fill_done = 1'b0; median_ready = 1'b0;
    win_size = '0; init_pivot = '0;
    lower_size = '0; equal_size = '0; larger_size = '0;
    min_lower = '0; max_lower = '0; min_larger = '0; max_larger = '0;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    mdl_on = 1'b1;
    step();

    // equal hit: k=4 inside [4,5)
    begin_win(9, 100);
    fill(4, 1, 4, 1, 99, 101, 250);
    expect_out(100, 9);
    handshake(3, 100);

    // lower iteration, then equal hit on pivot 30 pins k=4
    begin_win(9, 80);
    fill(6, 1, 2, 10, 50, 90, 99);
    expect_req(30, 6);
    fill(4, 1, 1, 10, 29, 31, 50);
    expect_out(30, 6);
    handshake(0, 30);

    // larger iteration, then equal hit pins k=1
    begin_win(9, 100);
    fill(2, 1, 6, 5, 90, 120, 200);
    expect_req(160, 6);
    fill(1, 1, 4, 120, 150, 170, 200);
    expect_out(160, 6);
    handshake(1, 160);

    // degenerate lower partition
    begin_win(9, 100);
    fill(5, 1, 3, 42, 42, 150, 200);
    expect_out(42, 5);
    handshake(2, 42);

    // reset in WAIT_FILL, then fill_done must not wake the controller
    begin_win(9, 100);
    rst = 1'b1; mdl_pivot = '0; mdl_buff = '0;
    #1;
    chk_reset_outputs("async_rst");
    step();
    rst = 1'b0;
    lower_size = 6'd4; equal_size = 6'd1; larger_size = 6'd4; fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sending", sending, 0);
    step();
    chk("post_rst_sreq", send_req, 0);
    chk("post_rst_valid", median_valid, 0);

    // reset while holding a result drops it
    begin_win(9, 100);
    fill(4, 1, 4, 1, 99, 101, 250);
    expect_out(100, 9);
    rst = 1'b1; mdl_pivot = '0; mdl_buff = '0;
    #1;
    chk("out_rst_valid", median_valid, 0);
    chk("out_rst_median", median, 0);
    step();
    rst = 1'b0;
    step();
    chk("out_rst_idle", busy, 0);
    chk("out_rst_valid2", median_valid, 0);

    repeat (40) run_random();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/median_select.md
MEDIAN_SELECT -- requirements
Module: median_select

Interface
REQ-001 SHALL have parameter BUFF_SIZE, default 32, meaning maximum window size in pixels.
REQ-002 SHALL have parameter BUFF_SIZE_BIT, default $clog2(BUFF_SIZE)+1, meaning the width of all size and position signals.
REQ-003 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  pulse that begins a new window.
REQ-006 SHALL have port win_size  input  BUFF_SIZE_BIT  pixel count of the window, sampled on an accepted start.
REQ-007 SHALL have port init_pivot  input  8  first pivot, sampled on an accepted start.
REQ-008 SHALL have port fill_done  input  1  partition stage has classified the whole buffer.
REQ-009 SHALL have ports lower_size, equal_size and larger_size  input  BUFF_SIZE_BIT each  partition counts.
REQ-010 SHALL have ports min_lower, max_lower, min_larger and max_larger  input  8 each  partition extremes.
REQ-011 SHALL have port pivot  output  8  current pivot, registered.
REQ-012 SHALL have port buff_size  output  BUFF_SIZE_BIT  current buffer size, registered.
REQ-013 SHALL have port send_req  output  1  one-cycle pulse that restarts the partition stage for the next iteration.
REQ-014 SHALL have port sending  output  1  high while a decision is pending or a request is issued.
REQ-015 SHALL have ports median  output  8  and median_valid  output  1, which together present the result.
REQ-016 SHALL have port median_ready  input  1  consumer accepts the result.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement an FSM with states IDLE, WAIT_FILL, DECIDE, REQ and OUT.
REQ-019 SHALL accept start only in IDLE, and SHALL ignore start in any other state.
- On an accepted start: pivot<=init_pivot, buff_size<=win_size, k<=(win_size-1)>>1, next state WAIT_FILL.
REQ-020 SHALL hold a position register k of BUFF_SIZE_BIT bits, giving the 0-based rank of the median within the current buffer.
REQ-021 SHALL move from WAIT_FILL to DECIDE on the first cycle fill_done=1 and SHALL register all partition inputs on that cycle.
REQ-022 SHALL resolve in DECIDE using the registered values (L=lower_size, E=equal_size):
- k<L: target lower, buff_size<=L, k unchanged.
- L<=k<L+E: median<=pivot, go to OUT.
- k>=L+E: target larger, k<=k-L-E, buff_size<=larger_size.
REQ-023 SHALL compute L+E at BUFF_SIZE_BIT width; no overflow occurs because L+E<=buff_size.
REQ-024 SHALL resolve a targeted partition with min==max directly: median<=min, go to OUT, and SHALL NOT issue send_req.
REQ-025 SHALL otherwise set pivot<=(min+max+1)>>1 of the targeted partition, using a 9-bit sum, and go to REQ.
- This guarantees min<pivot<=max, so the range strictly shrinks; at most 9 iterations occur.
REQ-026 SHALL make REQ last exactly one cycle with send_req=1, then go to WAIT_FILL.
REQ-027 SHALL drive sending=1 in DECIDE and REQ, and 0 in all other states.
REQ-028 SHALL ignore fill_done in any state other than WAIT_FILL.
REQ-029 SHALL hold median_valid=1 and median stable in OUT until median_ready=1, then go to IDLE on the next edge.
REQ-030 SHALL NOT accept a start arriving in the same cycle as the OUT-to-IDLE handshake.
REQ-031 SHALL have a latency of 1 cycle from the fill_done edge to the DECIDE decision, and 2 cycles to the send_req pulse.
REQ-032 SHALL let a partition of size zero never be targeted, because k<buff_size always holds.

Reset
REQ-033 SHALL, while rst=1 and in any state, asynchronously force: state=IDLE, pivot=0, buff_size=0, k=0, median=0, median_valid=0, send_req=0, sending=0, busy=0.
REQ-034 SHALL, on a reset during WAIT_FILL, REQ or OUT, drop the result and issue no send_req after the release of reset.

Verification
REQ-035 SHALL be covered by an equal-hit scenario: win_size=9, pivot=100, fill_done with L=4, E=1, larger=4 -> median=100, median_valid 1 cycle after DECIDE, no send_req.
REQ-036 SHALL be covered by a lower-iteration scenario: win_size=9, fill_done with L=6, min_lower=10, max_lower=50 -> send_req pulse 2 cycles after fill_done, pivot=30, buff_size=6, k=4.
REQ-037 SHALL be covered by a larger-iteration scenario: win_size=9, L=2, E=1, larger=6, min_larger=120, max_larger=200 -> pivot=160, buff_size=6, k=1.
REQ-038 SHALL be covered by a degenerate scenario: win_size=9, L=5, min_lower=max_lower=42 -> median=42, no send_req.
REQ-039 SHALL be covered by a backpressure scenario: median_ready held 0 for 3 cycles -> median_valid and median stable, start ignored; median_ready=1 -> IDLE next cycle.
REQ-040 SHALL be covered by a mid-operation reset scenario: rst pulsed in WAIT_FILL, then fill_done=1 -> no DECIDE, busy=0, outputs at reset values.
